// File: rtl/synapse_receiver.sv
// Synapse receive end: turns presynaptic spike pulses into a decaying, saturating
// signed synaptic current. Define PULSE_CHECK_EN to qualify pulses by HOLD_TIME length.
module synapse_receiver #(
    parameter int WIDTH       = 32,
    parameter int N_IN        = 4,
    parameter int HOLD_TIME   = 8,
    parameter int DECAY_SHIFT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_IN-1:0]         synin,
    input  logic [N_IN*WIDTH-1:0]   weights,
    output logic signed [WIDTH-1:0] I,
    output logic [N_IN-1:0]         event_o,
    output logic                    sat,
    output logic [N_IN-1:0]         pulse_err
);

    // Guard bits so N_IN full-scale weights plus the current can never wrap.
    localparam int SW = WIDTH + $clog2(N_IN) + 1;

    logic [N_IN-1:0]         r_s1;
    logic [N_IN-1:0]         r_s2;
    logic signed [WIDTH-1:0] r_i;
    logic [N_IN-1:0]         r_ev;
    logic                    r_sat;

    logic [N_IN-1:0]         w_ev;
    logic signed [WIDTH-1:0] w_d;
    logic signed [SW-1:0]    w_sum;
    logic                    w_ovf;
    logic signed [WIDTH-1:0] w_next;

    function automatic logic signed [SW-1:0] sext(input logic [WIDTH-1:0] v);
        return {{(SW-WIDTH){v[WIDTH-1]}}, v};
    endfunction

`ifdef PULSE_CHECK_EN
    localparam int HCW = $clog2(HOLD_TIME + 1);
    localparam logic [HCW-1:0] HOLD_C = HCW'(HOLD_TIME);

    logic [HCW-1:0]  r_hc [N_IN];
    logic [HCW-1:0]  w_hc_next [N_IN];
    logic [N_IN-1:0] r_err;
    logic [N_IN-1:0] w_err;

    // The event fires only on the cycle the high count first reaches HOLD_TIME.
    always_comb begin
        for (int k = 0; k < N_IN; k++) begin
            w_hc_next[k] = '0;
            if (r_s1[k] && !r_s2[k])
                w_hc_next[k] = HCW'(1);
            else if (r_s1[k])
                w_hc_next[k] = (r_hc[k] == HOLD_C) ? HOLD_C : r_hc[k] + HCW'(1);
            w_ev[k]  = (w_hc_next[k] == HOLD_C) && (r_hc[k] != HOLD_C);
            w_err[k] = !r_s1[k] && (r_hc[k] != '0) && (r_hc[k] < HOLD_C);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the counter array is cleared element by element so every
            // qualifier restarts cleanly; no state survives a reset.
            for (int k = 0; k < N_IN; k++) r_hc[k] <= '0;
            r_err <= '0;
        end else begin
            for (int k = 0; k < N_IN; k++) r_hc[k] <= w_hc_next[k];
            r_err <= w_err;
        end
    end

    assign pulse_err = r_err;
`else
    assign w_ev      = r_s1 & ~r_s2;
    assign pulse_err = '0;
`endif

    // Decay step is forced to +/-1 once the shift underflows, so I lands exactly on 0.
    always_comb begin
        w_d = r_i >>> DECAY_SHIFT;
        if (w_d == '0 && r_i != '0)
            w_d = r_i[WIDTH-1] ? '1 : {{(WIDTH-1){1'b0}}, 1'b1};

        w_sum = sext(r_i) - sext(w_d);
        for (int k = 0; k < N_IN; k++)
            if (w_ev[k]) w_sum = w_sum + sext(weights[k*WIDTH +: WIDTH]);

        w_ovf  = !((&w_sum[SW-1:WIDTH-1]) || !(|w_sum[SW-1:WIDTH-1]));
        w_next = w_sum[WIDTH-1:0];
        if (w_ovf)
            w_next = w_sum[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would chain s1 into s2.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_i   <= '0;
            r_ev  <= '0;
            r_sat <= 1'b0;
        end else begin
            r_s1  <= synin;
            r_s2  <= r_s1;
            r_i   <= w_next;
            r_ev  <= w_ev;
            r_sat <= w_ovf;
        end
    end

    assign I       = r_i;
    assign event_o = r_ev;
    assign sat     = r_sat;

endmodule

// File: tb/tb_synapse_receiver.sv
// Self-checking bench for synapse_receiver: directed scenarios plus randomized
// traffic compared each cycle against a sample-history / integer-arithmetic model.
module tb_synapse_receiver;

    localparam int WIDTH       = 32;
    localparam int N_IN        = 4;
    localparam int HOLD_TIME   = 8;
    localparam int DECAY_SHIFT = 4;
    localparam longint MAXV    = 64'sd2147483647;
    localparam longint MINV    = -64'sd2147483648;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_IN-1:0]         synin;
    logic [N_IN*WIDTH-1:0]   weights;
    logic signed [WIDTH-1:0] I;
    logic [N_IN-1:0]         event_o;
    logic                    sat;
    logic [N_IN-1:0]         pulse_err;

    synapse_receiver #(
        .WIDTH(WIDTH), .N_IN(N_IN), .HOLD_TIME(HOLD_TIME), .DECAY_SHIFT(DECAY_SHIFT)
    ) dut (
        .clk(clk), .reset(reset), .synin(synin), .weights(weights),
        .I(I), .event_o(event_o), .sat(sat), .pulse_err(pulse_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    string cur_test = "init";

    // Reference model state: last two sampled line values and run lengths of highs.
    logic signed [WIDTH-1:0] wt [N_IN];
    logic [N_IN-1:0] m_h0, m_h1;
    int     m_run  [N_IN];
    int     m_prev [N_IN];
    longint m_i;
    logic [N_IN-1:0] exp_ev, exp_err;
    logic            exp_sat;

    task automatic set_weights(input longint w0, input longint w1, input longint w2, input longint w3);
        wt[0] = w0[31:0]; wt[1] = w1[31:0]; wt[2] = w2[31:0]; wt[3] = w3[31:0];
        for (int k = 0; k < N_IN; k++) weights[k*WIDTH +: WIDTH] = wt[k];
    endtask

    task automatic step(input logic [N_IN-1:0] syn, input logic rst);
        longint d, sum;
        logic [WIDTH-1:0] exp_i;
        if (rst) begin
            m_i = 0; exp_ev = '0; exp_err = '0; exp_sat = 1'b0;
            m_h0 = '0; m_h1 = '0;
            for (int k = 0; k < N_IN; k++) begin m_run[k] = 0; m_prev[k] = 0; end
        end else begin
            for (int k = 0; k < N_IN; k++) begin
`ifdef PULSE_CHECK_EN
                exp_ev[k]  = m_h0[k] && (m_run[k] == HOLD_TIME);
                exp_err[k] = !m_h0[k] && (m_prev[k] > 0) && (m_prev[k] < HOLD_TIME);
`else
                exp_ev[k]  = m_h0[k] && !m_h1[k];
                exp_err[k] = 1'b0;
`endif
            end
            d = m_i >>> DECAY_SHIFT;
            if (d == 0 && m_i != 0) d = (m_i > 0) ? 64'sd1 : -64'sd1;
            sum = m_i - d;
            for (int k = 0; k < N_IN; k++) if (exp_ev[k]) sum = sum + longint'(wt[k]);
            exp_sat = 1'b0;
            if (sum > MAXV) begin sum = MAXV; exp_sat = 1'b1; end
            if (sum < MINV) begin sum = MINV; exp_sat = 1'b1; end
            m_i = sum;
            for (int k = 0; k < N_IN; k++) begin
                m_h1[k]   = m_h0[k];
                m_h0[k]   = syn[k];
                m_prev[k] = m_run[k];
                m_run[k]  = syn[k] ? ((m_run[k] < 1000) ? m_run[k] + 1 : 1000) : 0;
            end
        end
        exp_i = m_i[31:0];

        synin = syn;
        reset = rst;
        @(posedge clk);
        #1;
        checks++;
        if (I !== exp_i) begin
            errors++;
            $display("FAIL %s model_I: got %h expected %h", cur_test, I, exp_i);
        end
        checks++;
        if (event_o !== exp_ev) begin
            errors++;
            $display("FAIL %s model_event_o: got %b expected %b", cur_test, event_o, exp_ev);
        end
        checks++;
        if (sat !== exp_sat) begin
            errors++;
            $display("FAIL %s model_sat: got %b expected %b", cur_test, sat, exp_sat);
        end
        checks++;
        if (pulse_err !== exp_err) begin
            errors++;
            $display("FAIL %s model_pulse_err: got %b expected %b", cur_test, pulse_err, exp_err);
        end
    endtask

    task automatic test_reset();
        cur_test = "reset";
        set_weights(0, 0, 0, 0);
        step('0, 1'b1);
        step('0, 1'b1);
        checks++;
        if ({I, event_o, sat, pulse_err} !== '0) begin
            errors++;
            $display("FAIL reset_state: got I=%h ev=%b sat=%b perr=%b expected all zero",
                     I, event_o, sat, pulse_err);
        end
    endtask

    task automatic test_single_pulse();
        int n_ev = 0;
        int ev_at = -1;
        cur_test = "single_pulse";
        set_weights(64'h0001_0000, 0, 0, 0);
        step('0, 1'b1);
        step('0, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            step((c <= 8) ? 4'b0001 : 4'b0000, 1'b0);
            if (event_o[0]) begin n_ev++; ev_at = c; end
`ifndef PULSE_CHECK_EN
            if (c == 2) begin
                checks++;
                if (I !== 32'h0001_0000 || event_o !== 4'b0001) begin
                    errors++;
                    $display("FAIL pulse_first_update: got I=%h ev=%b expected 00010000 0001", I, event_o);
                end
            end
            if (c == 3) begin
                checks++;
                if (I !== 32'h0000_F000) begin
                    errors++;
                    $display("FAIL pulse_decay1: got %h expected 0000f000", I);
                end
            end
            if (c == 4) begin
                checks++;
                if (I !== 32'h0000_E100) begin
                    errors++;
                    $display("FAIL pulse_decay2: got %h expected 0000e100", I);
                end
            end
`endif
        end
        checks++;
        if (n_ev != 1) begin
            errors++;
            $display("FAIL pulse_event_count: got %0d expected 1", n_ev);
        end
`ifdef PULSE_CHECK_EN
        checks++;
        if (ev_at != 9) begin
            errors++;
            $display("FAIL pulse_check_latency: event at step %0d expected 9", ev_at);
        end
`else
        checks++;
        if (ev_at != 2) begin
            errors++;
            $display("FAIL pulse_latency: event at step %0d expected 2", ev_at);
        end
`endif
    endtask

    task automatic test_simultaneous();
        cur_test = "simultaneous";
        set_weights(64'h0001_0000, 64'hFFFF_8000, 0, 0);
        step('0, 1'b1);
        step('0, 1'b0);
        step(4'b0011, 1'b0);
        step(4'b0011, 1'b0);
`ifndef PULSE_CHECK_EN
        checks++;
        if (I !== 32'h0000_8000 || event_o !== 4'b0011 || sat !== 1'b0) begin
            errors++;
            $display("FAIL simultaneous_sum: got I=%h ev=%b sat=%b expected 00008000 0011 0",
                     I, event_o, sat);
        end
`endif
        for (int c = 0; c < 10; c++) step(4'b0011, 1'b0);
        for (int c = 0; c < 4; c++) step(4'b0000, 1'b0);
    endtask

    task automatic test_saturation();
        cur_test = "saturation";
        set_weights(64'h7FFF_0000, 64'h7FFF_0000, 64'h7FFF_0000, 64'h7FFF_0000);
        step('0, 1'b1);
        step('0, 1'b0);
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
`ifndef PULSE_CHECK_EN
        checks++;
        if (I !== 32'h7FFF_FFFF || sat !== 1'b1) begin
            errors++;
            $display("FAIL sat_clamp: got I=%h sat=%b expected 7fffffff 1", I, sat);
        end
        step(4'b1111, 1'b0);
        checks++;
        if (I !== 32'h7800_0000 || sat !== 1'b0) begin
            errors++;
            $display("FAIL sat_release: got I=%h sat=%b expected 78000000 0", I, sat);
        end
`endif
        for (int c = 0; c < 10; c++) step(4'b1111, 1'b0);
    endtask

    task automatic test_decay_floor();
        cur_test = "decay_floor";
        set_weights(64'h0000_0001, 64'hFFFF_FFFF, 0, 0);
        step('0, 1'b1);
        step('0, 1'b0);
        step(4'b0001, 1'b0);
        for (int c = 0; c < HOLD_TIME; c++) step(4'b0001, 1'b0);
        for (int c = 0; c < 12; c++) begin
            step(4'b0000, 1'b0);
            if (I == 32'h0000_0001) begin
                step(4'b0000, 1'b0);
                checks++;
                if (I !== 32'h0) begin
                    errors++;
                    $display("FAIL floor_positive: got %h expected 00000000", I);
                end
                break;
            end
        end
        for (int c = 0; c <= HOLD_TIME; c++) step(4'b0010, 1'b0);
        for (int c = 0; c < 12; c++) begin
            step(4'b0000, 1'b0);
            if (I == 32'hFFFF_FFFF) begin
                step(4'b0000, 1'b0);
                checks++;
                if (I !== 32'h0) begin
                    errors++;
                    $display("FAIL floor_negative: got %h expected 00000000", I);
                end
                break;
            end
        end
        for (int c = 0; c < 4; c++) step(4'b0000, 1'b0);
        checks++;
        if (I !== 32'h0) begin
            errors++;
            $display("FAIL floor_stays_zero: got %h expected 00000000", I);
        end
    endtask

    task automatic test_reset_mid_pulse();
        int n_ev = 0;
        cur_test = "reset_mid_pulse";
        set_weights(64'h0001_0000, 0, 0, 0);
        step('0, 1'b1);
        step('0, 1'b0);
        for (int c = 0; c < 12; c++) step(4'b0001, 1'b0);
        step(4'b0001, 1'b1);
        checks++;
        if (I !== 32'h0 || event_o !== 4'b0 || sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_pulse_clear: got I=%h ev=%b sat=%b expected 0 0 0", I, event_o, sat);
        end
        for (int c = 0; c < 14; c++) begin
            step(4'b0001, 1'b0);
            if (event_o[0]) n_ev++;
        end
        checks++;
        if (n_ev != 1) begin
            errors++;
            $display("FAIL reset_release_event_count: got %0d expected 1", n_ev);
        end
        for (int c = 0; c < 4; c++) step(4'b0000, 1'b0);
    endtask

`ifdef PULSE_CHECK_EN
    task automatic test_runt_pulse();
        int n_ev = 0;
        int n_err = 0;
        cur_test = "runt_pulse";
        set_weights(64'h0001_0000, 0, 0, 0);
        step('0, 1'b1);
        step('0, 1'b0);
        for (int c = 0; c < 3; c++) step(4'b0001, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step(4'b0000, 1'b0);
            if (event_o[0]) n_ev++;
            if (pulse_err[0]) n_err++;
        end
        checks++;
        if (n_ev != 0 || n_err != 1 || I !== 32'h0) begin
            errors++;
            $display("FAIL runt_pulse: got events=%0d errs=%0d I=%h expected 0 1 0", n_ev, n_err, I);
        end
    endtask
`endif

    task automatic test_random();
        logic [N_IN-1:0] syn = '0;
        cur_test = "random";
        step('0, 1'b1);
        for (int c = 0; c < 600; c++) begin
            if (c % 16 == 0) begin
                for (int k = 0; k < N_IN; k++) begin
                    case ($urandom_range(0, 3))
                        0: wt[k] = $urandom;
                        1: wt[k] = 32'($signed($urandom_range(0, 32'h0004_0000)) - 32'sh0002_0000);
                        2: wt[k] = ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
                        default: wt[k] = '0;
                    endcase
                    weights[k*WIDTH +: WIDTH] = wt[k];
                end
            end
            for (int k = 0; k < N_IN; k++)
                if ($urandom_range(0, 5) == 0) syn[k] = ~syn[k];
            step(syn, ($urandom_range(0, 99) == 0));
        end
    endtask

    initial begin
        reset   = 1'b1;
        synin   = '0;
        weights = '0;
        m_i = 0; m_h0 = '0; m_h1 = '0;
        exp_ev = '0; exp_err = '0; exp_sat = 1'b0;
        for (int k = 0; k < N_IN; k++) begin m_run[k] = 0; m_prev[k] = 0; wt[k] = '0; end
        test_reset();
        test_single_pulse();
        test_simultaneous();
        test_saturation();
        test_decay_floor();
        test_reset_mid_pulse();
`ifdef PULSE_CHECK_EN
        test_runt_pulse();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/synapse_receiver.md
Name: synapse_receiver

Overview:
- Receive end of the spike interface: takes N_IN presynaptic synout lines, each a pulse held high HOLD_TIME cycles, and produces the signed Q16.16 synaptic current I that feeds a neuron's I input.
- Each accepted spike adds that input's signed weight to I.
- I decays exponentially toward 0 every cycle and saturates to the signed WIDTH range.

Parameters:
- WIDTH, 32, data width of weights and I (signed Q16.16 when 32)
- N_IN, 4, number of presynaptic spike inputs (>=1)
- HOLD_TIME, 8, transmitter pulse length in cycles (>=2); used only with PULSE_CHECK_EN
- DECAY_SHIFT, 4, decay per cycle is I >>> DECAY_SHIFT (1..WIDTH-2)

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- synin  input  N_IN  presynaptic spike lines, bit k = input k
- weights  input  N_IN*WIDTH  flattened signed weights; weight k = bits [k*WIDTH +: WIDTH]; sampled combinationally at the update edge
- I  output  WIDTH  signed synaptic current, registered
- event_o  output  N_IN  registered; bit k high for exactly 1 cycle, concurrent with the I update that includes weight k
- sat  output  1  registered; high for 1 cycle when that cycle's I update was clamped
- pulse_err  output  N_IN  registered; 1-cycle flag for a runt pulse; tied 0 without PULSE_CHECK_EN

Behaviour:
- Reset: on a posedge with reset=1, the following all clear to 0: I, event_o, sat, pulse_err, all input sample registers and all counters. Reset overrides everything, including mid-pulse and mid-decay. After reset release, a line already high counts as a rising edge only if it was sampled low first; the sample registers clear to 0, so a line held high through reset produces one event.
- Input sampling, per input k: s1[k] <= synin[k]; s2[k] <= s1[k].
- Event detection, default: raw event ev[k] = s1[k] & ~s2[k], one per rising edge. A held level never re-triggers.
- Latency: if synin[k] is first sampled high at edge N, then event_o[k]=1 and I includes weight k after edge N+1.
- Update, every non-reset edge:
  - d = I >>> DECAY_SHIFT (arithmetic shift).
  - If d==0 and I!=0, d = +1 for I>0, or -1 for I<0. This guarantees I reaches exactly 0.
  - sum = I - d + SUM over k with ev[k]=1 of weight[k].
  - Compute sum at WIDTH + clog2(N_IN) + 1 bits, sign-extended.
  - Clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. sat = 1 if the clamp changed the value.
  - I <= clamped sum; event_o <= ev.
- Simultaneous events on several inputs: all weights are summed in the same cycle; no event is dropped or deferred.
- Zero weight: the event is still flagged on event_o; I only decays.
- I=0 with no events: I stays 0.

Optional Feature:
- Macro: PULSE_CHECK_EN.
- Defined:
  - Per input, a high counter hc[k] of width clog2(HOLD_TIME+1).
  - hc[k] resets to 1 on the rising edge s1&~s2, increments while s1=1 and saturates at HOLD_TIME. It clears to 0 when s1=0.
  - ev[k] fires once, in the cycle where hc[k] becomes HOLD_TIME. Added latency is HOLD_TIME-1 cycles versus the default.
  - If s1 falls while 0 < hc[k] < HOLD_TIME, pulse_err[k] is 1 for one cycle and no event occurs.
  - Pulses longer than HOLD_TIME still give exactly one event.
- Undefined: edge-triggered detection as in Behaviour; pulse_err is tied 0; no hc registers.

Test Plan:
- Reset, then a single pulse on synin[0] for 8 cycles with weight0=0x0001_0000, others 0 -> at edge N+1: I=0x0001_0000 and event_o=0001. Next edge: I=0x0000_F000. Then 0x0000_E100. Only one event for the whole pulse.
- synin[0] and synin[1] rise in the same cycle, weights 0x0001_0000 and 0xFFFF_8000, I=0 -> I=0x0000_8000, event_o=0011, sat=0.
- Four inputs rise together, each weight 0x7FFF_0000 -> I=0x7FFF_FFFF, sat=1 for one cycle. Next cycle: sat=0 and I=0x7800_0000 (0x7FFF_FFFF - 0x07FF_FFFF).
- Decay floor: I=0x0000_0001 with no input -> next cycle I=0. Also I=0xFFFF_FFFF -> next cycle I=0, and I stays 0 afterwards.
- Reset asserted mid-pulse with I nonzero -> I=0, event_o=0, sat=0 at the next edge. Line still high at release -> exactly one event.
- With PULSE_CHECK_EN and HOLD_TIME=8:
  - 3-cycle pulse -> pulse_err[0] for 1 cycle, no event, I unchanged apart from decay.
  - 8-cycle pulse -> exactly one event, with I updated 8 edges after the first high sample.
